// File: rtl/router_pkt_ctrl.sv
// Ingress packet controller: decodes the header address, steers bytes into one of
// three FIFOs, stalls the source on full/non-empty FIFOs and checks parity and length.
module router_pkt_ctrl #(
  parameter int DATA_W     = 8,
  parameter bit WAIT_EMPTY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        soft_rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        fifo_full,
  input  logic [2:0]        fifo_empty,
  output logic              busy,
  output logic [2:0]        write_enb,
  output logic              lfd_state,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              err
);

  localparam int LEN_W = DATA_W - 2;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_WAIT,
    ST_LOAD_FIRST,
    ST_LOAD,
    ST_CHECK,
    ST_DROP
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  hdr_q;
  logic [1:0]         addr_q;
  logic [DATA_W-1:0]  par_q;
  logic [DATA_W-1:0]  rxpar_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               err_q;

  logic [1:0] hdr_addr;
  logic [2:0] hdr_sel;
  logic [2:0] sel;
  logic       hdr_empty;
  logic       dst_empty;
  logic       dst_full;
  logic       abort;

  // Address 2'b11 shifts out of the 3-bit vector, so hdr_sel is all zero for it.
  assign hdr_addr  = data_in[1:0];
  assign hdr_sel   = 3'b001 << hdr_addr;
  assign sel       = 3'b001 << addr_q;
  assign hdr_empty = |(fifo_empty & hdr_sel);
  assign dst_empty = |(fifo_empty & sel);
  assign dst_full  = |(fifo_full & sel);

  always_comb begin
    abort = 1'b0;
    if (state_q == ST_WAIT || state_q == ST_LOAD_FIRST ||
        state_q == ST_LOAD || state_q == ST_CHECK)
      abort = |(soft_rst & sel);
  end

  // Outputs are decoded from state so that rst clears them asynchronously with the state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    busy        = 1'b0;
    write_enb   = 3'b000;
    lfd_state   = 1'b0;
    dout        = '0;
    parity_done = 1'b0;
    unique case (state_q)
      ST_DECODE: ;
      ST_WAIT: busy = 1'b1;
      ST_LOAD_FIRST: begin
        busy = 1'b1;
        if (!abort) begin
          write_enb = sel;
          lfd_state = 1'b1;
          dout      = hdr_q;
        end
      end
      ST_LOAD: begin
        busy = dst_full;
        if (!abort && !dst_full) begin
          write_enb = sel;
          dout      = data_in;
        end
      end
      ST_CHECK: begin
        busy        = 1'b1;
        parity_done = 1'b1;
      end
      ST_DROP: ;
      default: ;
    endcase
  end

  assign err = err_q;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DECODE;
      hdr_q   <= '0;
      addr_q  <= '0;
      par_q   <= '0;
      rxpar_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_DECODE: begin
          if (pkt_valid) begin
            if (hdr_addr == 2'b11) begin
              state_q <= ST_DROP;
            end else begin
              hdr_q   <= data_in;
              addr_q  <= hdr_addr;
              par_q   <= data_in;
              cnt_q   <= '0;
              state_q <= (hdr_empty || !WAIT_EMPTY) ? ST_LOAD_FIRST : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (abort)          state_q <= ST_DECODE;
          else if (dst_empty) state_q <= ST_LOAD_FIRST;
        end
        ST_LOAD_FIRST: begin
          state_q <= abort ? ST_DECODE : ST_LOAD;
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_DECODE;
          end else if (!dst_full) begin
            if (pkt_valid) begin
              par_q <= par_q ^ data_in;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else begin
              rxpar_q <= data_in;
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!abort)
            err_q <= (par_q != rxpar_q) || (cnt_q != hdr_q[DATA_W-1:2]);
          state_q <= ST_DECODE;
        end
        ST_DROP: begin
          if (!pkt_valid) state_q <= ST_DECODE;
        end
        default: state_q <= ST_DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: the stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_router_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] soft_rst;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] dout;
  logic       parity_done;
  logic       err;

  typedef struct {
    logic [2:0] we;
    logic       lfd;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  router_pkt_ctrl #(.DATA_W(8), .WAIT_EMPTY(1'b1)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .busy(busy), .write_enb(write_enb), .lfd_state(lfd_state), .dout(dout),
    .parity_done(parity_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (write_enb !== 3'b000) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got we=%b lfd=%b d=%h expected none at %0t",
                 write_enb, lfd_state, dout, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({write_enb, lfd_state, dout} !== {e.we, e.lfd, e.d}) begin
          miscompares++;
          $display("FAIL fifo_write: got we=%b lfd=%b d=%h expected we=%b lfd=%b d=%h at %0t",
                   write_enb, lfd_state, dout, e.we, e.lfd, e.d, $time);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] addr, input logic lfd, input logic [7:0] d);
    wr_t e;
    e.we  = 3'b001 << addr;
    e.lfd = lfd;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  // Present one byte and hold it until an edge where busy=0 consumes it.
  task automatic send_byte(input logic valid, input logic [7:0] d);
    bit done = 0;
    pkt_valid = valid;
    data_in   = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got busy=1 for 50 cycles expected consume of %h", d);
    end
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'((i * 37 + 5) ^ 8'hA4);
  endfunction

  // Payload bytes; optionally raise fifo_full for full_cyc cycles in front of byte full_idx.
  task automatic send_payload(input logic [1:0] addr, input int n, input int full_idx,
                              input int full_cyc, input logic [7:0] par_in,
                              output logic [7:0] par_out);
    logic [7:0] p = par_in;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b = pay(i);
      if (i == full_idx) begin
        pkt_valid = 1'b1;
        data_in   = b;
        fifo_full[addr] = 1'b1;
        for (int k = 0; k < full_cyc; k++) begin
          @(negedge clk);
          check("full_busy", 32'(busy), 32'd1);
          check("full_no_write", 32'(write_enb), 32'd0);
          @(posedge clk);
          #1;
        end
        fifo_full[addr] = 1'b0;
      end
      push_exp(addr, 1'b0, b);
      p = p ^ b;
      send_byte(1'b1, b);
    end
    par_out = p;
  endtask

  // Parity byte, then the CHECK cycle: one parity_done pulse and the new err value.
  task automatic send_parity(input logic [1:0] addr, input logic [7:0] p, input logic exp_err);
    push_exp(addr, 1'b0, p);
    send_byte(1'b0, p);
    pkt_valid = 1'b0;
    @(negedge clk);
    check("parity_done_pulse", 32'(parity_done), 32'd1);
    @(posedge clk);
    #1;
    check("err_after_check", 32'(err), 32'(exp_err));
    @(negedge clk);
    check("parity_done_single", 32'(parity_done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] flip,
                             input int full_idx, input int full_cyc, input logic exp_err);
    logic [7:0] p;
    push_exp(hdr[1:0], 1'b1, hdr);
    send_byte(1'b1, hdr);
    send_payload(hdr[1:0], int'(hdr[7:2]), full_idx, full_cyc, hdr, p);
    send_parity(hdr[1:0], p ^ flip, exp_err);
  endtask

  initial begin
    logic [7:0] p;
    rst = 1'b1; soft_rst = 3'b000; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_enb", 32'(write_enb), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_err", 32'(err), 32'd0);
    check("rst_parity_done", 32'(parity_done), 32'd0);

    // Good packet, then bad parity, then good again.
    send_packet(8'h39, 8'h00, -1, 0, 1'b0);
    send_packet(8'h39, 8'h01, -1, 0, 1'b1);
    send_packet(8'h39, 8'h00, -1, 0, 1'b0);

    // Destination full for 3 cycles at payload byte 5.
    send_packet(8'h39, 8'h00, 4, 3, 1'b0);

    // Destination not empty: header held in WAIT until empty rises.
    fifo_empty[2] = 1'b0;
    push_exp(2'd2, 1'b1, 8'h12);
    send_byte(1'b1, 8'h12);
    data_in = pay(0);
    repeat (4) begin
      @(negedge clk);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_no_write", 32'(write_enb), 32'd0);
      @(posedge clk);
      #1;
    end
    fifo_empty[2] = 1'b1;
    @(negedge clk);
    check("wait_empty_rise", 32'(write_enb), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wait_hdr_lfd", 32'(lfd_state), 32'd1);
    check("wait_hdr_we", 32'(write_enb), 32'b100);
    @(posedge clk);
    #1;
    send_payload(2'd2, 4, -1, 0, 8'h12, p);
    send_parity(2'd2, p, 1'b0);

    // Zero-length packet: parity equals the header.
    send_packet(8'h02, 8'h00, -1, 0, 1'b0);

    // Address 11 is dropped without any write.
    send_byte(1'b1, 8'h0B);
    data_in = 8'h55;
    #1;
    check("drop_busy", 32'(busy), 32'd0);
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'hAA);
    send_byte(1'b0, 8'h77);
    pkt_valid = 1'b0;
    @(negedge clk);
    check("drop_done_busy", 32'(busy), 32'd0);
    check("drop_no_check", 32'(parity_done), 32'd0);
    check("drop_err_kept", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Soft reset of other FIFOs is ignored; soft_rst[0] aborts a packet to FIFO0.
    push_exp(2'd0, 1'b1, 8'h14);
    send_byte(1'b1, 8'h14);
    soft_rst = 3'b110;
    push_exp(2'd0, 1'b0, 8'hC1);
    send_byte(1'b1, 8'hC1);
    soft_rst = 3'b000;
    push_exp(2'd0, 1'b0, 8'hC2);
    send_byte(1'b1, 8'hC2);
    data_in = 8'hC3;
    soft_rst = 3'b001;
    @(negedge clk);
    check("soft_no_write", 32'(write_enb), 32'd0);
    @(posedge clk);
    #1;
    soft_rst = 3'b000;
    pkt_valid = 1'b0;
    @(negedge clk);
    check("soft_decode_busy", 32'(busy), 32'd0);
    check("soft_no_check", 32'(parity_done), 32'd0);
    check("soft_err_kept", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    send_packet(8'h14, 8'h00, -1, 0, 1'b0);

    // Bad packet sets err, then rst mid-LOAD clears everything at once.
    send_packet(8'h39, 8'h80, -1, 0, 1'b1);
    push_exp(2'd1, 1'b1, 8'h39);
    send_byte(1'b1, 8'h39);
    push_exp(2'd1, 1'b0, 8'h01);
    send_byte(1'b1, 8'h01);
    push_exp(2'd1, 1'b0, 8'h02);
    send_byte(1'b1, 8'h02);
    data_in = 8'h03;
    #1;
    check("pre_rst_we", 32'(write_enb), 32'b010);
    rst = 1'b1;
    #1;
    check("rst_mid_we", 32'(write_enb), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_lfd", 32'(lfd_state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_err", 32'(err), 32'd0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
